// File: rtl/sigmoid_lut_reader_if.sv
//==============================================================================
// Module  : sigmoid_lut_reader_if
// Brief   : Input stream, ROM port and output stream of the sigmoid LUT reader.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface sigmoid_lut_reader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_x;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_y;

    // The sigmoid block itself.
    modport slave (
        input  in_valid,
        output in_ready,
        input  in_x,
        output rom_addr,
        input  rom_data,
        output out_valid,
        input  out_ready,
        output out_y
    );

    // Surrounding environment: upstream producer, ROM and downstream consumer.
    modport master (
        output in_valid,
        input  in_ready,
        output in_x,
        input  rom_addr,
        output rom_data,
        input  out_valid,
        output out_ready,
        input  out_y
    );
endinterface

`default_nettype wire

// File: rtl/sigmoid_lut_reader.sv
//==============================================================================
// Module  : sigmoid_lut_reader
// Brief   : Full-range sigmoid from a half-range ROM using sigmoid(-x)=1-sigmoid(x).
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module sigmoid_lut_reader #(
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 8,
    parameter int ADDR_W     = 6,
    parameter int STEP_SHIFT = 5,
    parameter int LUT_MAX    = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sigmoid_lut_reader_if.slave  bus
);

    localparam int                  c_MAG_W    = DATA_W + 1;
    localparam int                  c_OUT_W    = 8;
    localparam logic [c_MAG_W-1:0]  c_ROUND    = c_MAG_W'(1 << (STEP_SHIFT - 1));
    localparam logic [c_MAG_W-1:0]  c_LUT_MAX  = c_MAG_W'(LUT_MAX);
    localparam logic [ADDR_W-1:0]   c_ADDR_MAX = ADDR_W'(LUT_MAX);

    if (STEP_SHIFT < 1 || STEP_SHIFT > FRAC_W || LUT_MAX >= (1 << ADDR_W)) begin : g_bad_params
        $error("sigmoid_lut_reader: inconsistent STEP_SHIFT/FRAC_W/LUT_MAX/ADDR_W");
    end

    logic                r_a_valid;
    logic                r_a_neg;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_y;

    logic                w_adv;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_neg;
    logic [c_MAG_W-1:0]  w_x_ext;
    logic [c_MAG_W-1:0]  w_mag;
    logic [c_MAG_W-1:0]  w_sum;
    logic [c_MAG_W-1:0]  w_idx;
    logic [ADDR_W-1:0]   w_addr;
    logic [c_OUT_W-1:0]  w_d;
    logic [c_OUT_W-1:0]  w_y;
    logic                w_unused_rom_hi;

    assign w_adv      = !r_out_valid || bus.out_ready;
    assign w_in_ready = !r_a_valid || w_adv;
    assign w_accept   = bus.in_valid && w_in_ready;

    // One extra bit so that the most negative input has a representable magnitude.
    assign w_neg   = bus.in_x[DATA_W-1];
    assign w_x_ext = {bus.in_x[DATA_W-1], bus.in_x};
    assign w_mag   = w_neg ? (~w_x_ext + c_MAG_W'(1)) : w_x_ext;
    assign w_sum   = w_mag + c_ROUND;
    assign w_idx   = w_sum >> STEP_SHIFT;
    assign w_addr  = (w_idx > c_LUT_MAX) ? c_ADDR_MAX : w_idx[ADDR_W-1:0];

    // 256 - d truncated to 8 bits; ROM never returns 0, so negatives never yield 0.
    assign w_d = bus.rom_data[c_OUT_W-1:0];
    assign w_y = r_a_neg ? (c_OUT_W'(0) - w_d) : w_d;

    assign w_unused_rom_hi = ^bus.rom_data[DATA_W-1:c_OUT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid  <= 1'b0;
            r_a_neg    <= 1'b0;
            r_rom_addr <= '0;
        end else if (w_accept) begin
            r_a_valid  <= 1'b1;
            r_a_neg    <= w_neg;
            r_rom_addr <= w_addr;
        end else if (w_adv) begin
            r_a_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
        end else if (r_a_valid && w_adv) begin
            r_out_valid <= 1'b1;
            r_out_y     <= {{(DATA_W - c_OUT_W){1'b0}}, w_y};
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.rom_addr  = r_rom_addr;
    assign bus.out_valid = r_out_valid;
    assign bus.out_y     = r_out_y;

endmodule

`default_nettype wire

// File: tb/tb_sigmoid_lut_reader.sv
//==============================================================================
// Module  : tb_sigmoid_lut_reader
// Brief   : Self-checking bench for sigmoid_lut_reader with a behavioural model.
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sigmoid_lut_reader;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 6;
    localparam int LUT_MAX = 48;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sigmoid_lut_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sigmoid_lut_reader #(
        .DATA_W     (DATA_W),
        .FRAC_W     (8),
        .ADDR_W     (ADDR_W),
        .STEP_SHIFT (5),
        .LUT_MAX    (LUT_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Half-range ROM; junk upper byte and out-of-range entries expose misuse.
    logic [7:0] rom [64];
    assign bus.rom_data = {8'hA5, rom[bus.rom_addr]};

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] sb [$];
    bit          prev_stall      = 1'b0;
    bit          prev_full_stall = 1'b0;
    logic [15:0] prev_y          = '0;
    logic [5:0]  prev_addr       = '0;
    bit          saw_block       = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_idx(input logic [15:0] x);
        int v;
        int mag;
        int idx;
        v   = int'($signed(x));
        mag = (v < 0) ? -v : v;
        idx = (mag + 16) / 32;
        return (idx > LUT_MAX) ? LUT_MAX : idx;
    endfunction

    function automatic logic [15:0] model_y(input logic [15:0] x);
        int d;
        d = int'(rom[model_idx(x)]);
        return ($signed(x) < 0) ? 16'((256 - d) % 256) : 16'(d);
    endfunction

    function automatic logic [15:0] rand_x();
        logic [15:0] edges [10];
        edges = '{16'h0000, 16'h000F, 16'h0010, 16'hFFF0, 16'h7FFF,
                  16'h8000, 16'h0600, 16'h05EF, 16'hFA00, 16'hFFF1};
        case ($urandom_range(0, 2))
            0:       return 16'(int'($urandom_range(0, 4095)) - 2048);
            1:       return edges[$urandom_range(0, 9)];
            default: return 16'($urandom);
        endcase
    endfunction

    // One clock: drive at the falling edge, observe 1ns later, update the model.
    task automatic cycle(input bit iv, input logic [15:0] x, input bit ordy, output bit acc);
        int occ;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_x      = x;
        bus.out_ready = ordy;
        #1;
        occ = sb.size();
        chk("addr_range", 32'(bus.rom_addr <= LUT_MAX), 32'd1);
        chk("in_ready", 32'(bus.in_ready), (occ < 2) ? 32'd1 : 32'(ordy));
        if (occ == 2 && !ordy) saw_block = 1'b1;
        if (prev_stall) begin
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_y", 32'(bus.out_y), 32'(prev_y));
        end
        if (prev_full_stall) chk("stall_addr", 32'(bus.rom_addr), 32'(prev_addr));
        if (bus.out_valid && ordy) begin
            if (sb.size() == 0) chk("spurious_out", 32'(bus.out_valid), 32'd0);
            else                chk("data", 32'(bus.out_y), 32'(sb.pop_front()));
        end
        acc = iv && bus.in_ready;
        if (acc) sb.push_back(model_y(x));
        prev_stall      = bus.out_valid && !ordy;
        prev_full_stall = prev_stall && (occ == 2);
        prev_y          = bus.out_y;
        prev_addr       = bus.rom_addr;
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0 && !bus.out_valid) break;
            cycle(1'b0, 16'h0000, 1'b1, acc);
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic directed(input string tag, input logic [15:0] x,
                            input logic [5:0] ea, input logic [15:0] ey);
        bit acc;
        drain();
        cycle(1'b1, x, 1'b1, acc);
        chk({tag, "_acc"}, 32'(acc), 32'd1);
        cycle(1'b0, 16'h0000, 1'b1, acc);
        chk({tag, "_addr"}, 32'(bus.rom_addr), 32'(ea));
        chk({tag, "_lat"}, 32'(bus.out_valid), 32'd0);
        cycle(1'b0, 16'h0000, 1'b1, acc);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_y"}, 32'(bus.out_y), 32'(ey));
    endtask

    initial begin
        bit          acc;
        int          sent;
        logic [15:0] x;

        for (int i = 0; i < 64; i++) begin
            if (i <= LUT_MAX) begin
                int v;
                v = $rtoi(256.0 / (1.0 + $exp(-(real'(i) * 0.125))) + 0.5);
                rom[i] = 8'((v > 255) ? 255 : v);
            end else begin
                rom[i] = 8'hEE;
            end
        end

        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.out_ready = 1'b0;

        @(negedge clk);
        #1;
        chk("rst_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_y", 32'(bus.out_y), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        directed("zero",     16'h0000, 6'd0,  16'h0080);
        directed("pos_half", 16'h0080, 6'd4,  16'h009F);
        directed("neg_half", 16'hFF80, 6'd4,  16'h0061);
        directed("rnd_dn",   16'h000F, 6'd0,  16'h0080);
        directed("rnd_up",   16'h0010, 6'd1,  16'h0088);
        directed("rnd_neg",  16'hFFF0, 6'd1,  16'h0078);
        directed("sat_p8",   16'h0800, 6'd48, 16'h00FF);
        directed("sat_n8",   16'hF800, 6'd48, 16'h0001);
        directed("sat_pmax", 16'h7FFF, 6'd48, 16'h00FF);
        directed("sat_nmax", 16'h8000, 6'd48, 16'h0001);

        // Backpressure: 10 samples with out_ready 1,0,0,1,0,0,...
        drain();
        sent = 0;
        x = rand_x();
        for (int c = 0; c < 200 && sent < 10; c++) begin
            cycle(1'b1, x, (c % 3) == 0, acc);
            if (acc) begin
                sent++;
                x = rand_x();
            end
        end
        chk("bp_sent", 32'(sent), 32'd10);
        drain();
        chk("bp_full_seen", 32'(saw_block), 32'd1);

        // Randomised traffic; an offered sample is held until accepted.
        x = rand_x();
        for (int c = 0; c < 600; c++) begin
            bit iv;
            iv = ($urandom_range(0, 3) != 0);
            cycle(iv, x, $urandom_range(0, 2) != 0, acc);
            if (acc) x = rand_x();
        end
        drain();

        // Reset with two samples in flight.
        cycle(1'b1, 16'h0123, 1'b0, acc);
        cycle(1'b1, 16'hFE00, 1'b0, acc);
        chk("inflight", 32'(sb.size()), 32'd2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_addr", 32'(bus.rom_addr), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        sb.delete();
        prev_stall      = 1'b0;
        prev_full_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        directed("post_rst", 16'hFF80, 6'd4, 16'h0061);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
